ldpc_job_sched: RTL and testbench
=================================

# ldpc_job_sched

Job scheduler and sequencer for the LDPC encoder/decoder core in the user project area. It accepts encode/decode job requests from two requesters: requester 0 is the Wishbone register front-end, requester 1 is the logic-analyzer control path. It shares the single codec core between them with round-robin arbitration, then drives the core's start/abort controls and enforces an iteration cap and a watchdog timeout. It returns a per-job status to the owning requester and raises an interrupt pulse on job completion.

## Interface
Parameters:
- ITER_MAX, 16: upper clamp for the decoder iteration budget; range 1..31.
- TIMEOUT_CYCLES, 1024: RUN-state watchdog limit in clock cycles; must be ≥ 2.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid_i  in  2  job request per requester; held until accepted.
- req_mode_i  in  2  per-requester mode bit; 0 = encode, 1 = decode.
- req_iter_i  in  10  per-requester 5-bit iteration budget; [4:0] is requester 0, [9:5] is requester 1.
- req_ready_o  out  2  one-cycle accept pulse to the granted requester.
- core_start_o  out  1  one-cycle start pulse to the codec.
- core_mode_o  out  1  mode of the current job; held from START to the end of RESP.
- core_max_iter_o  out  5  clamped iteration budget; held like core_mode_o.
- core_done_i  in  1  codec completion pulse.
- core_converged_i  in  1  decoder syndrome is zero; sampled with core_done_i.
- core_abort_o  out  1  one-cycle abort pulse on timeout.
- rsp_valid_o  out  2  response valid to the owning requester.
- rsp_status_o  out  2  00 = ok, 01 = not converged, 10 = timeout.
- rsp_ack_i  in  2  response acknowledge per requester.
- busy_o  out  1  high in every state except IDLE.
- irq_o  out  1  one-cycle pulse on entry to RESP.
- jobs_done_o  out  16  completed-job counter (see Configuration).
- timeouts_o  out  8  timeout counter (see Configuration).

Reset value of every output is 0. The round-robin pointer resets to favour requester 0.

## Operation
- IDLE → ARB when any req_valid_i bit is set.
- ARB: grant one requester. If only one requests, it wins. If both request, the one not granted last wins. Pulse req_ready_o[grant]. Latch owner, mode and clamped iteration budget. Go to START.
- Iteration clamp: 0 → 1; values above ITER_MAX → ITER_MAX; otherwise pass through. Encode jobs carry the clamped value too; the core ignores it.
- START: pulse core_start_o, clear the watchdog counter, go to RUN.
- RUN: increment the watchdog each cycle.
  - On core_done_i, latch status and go to RESP. Encode done gives 00. Decode done gives 00 if core_converged_i is set, else 01.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without core_done_i, go to ABORT.
  - If core_done_i arrives in the same cycle as the timeout, done wins.
- ABORT: pulse core_abort_o, set status 10, go to RESP.
- RESP: hold rsp_valid_o[owner] and rsp_status_o until rsp_ack_i[owner]. Acks from the non-owner are ignored. On ack, clear both outputs and go to IDLE.
- core_done_i outside RUN is ignored.
- A requester deasserting req_valid_i before its grant is legal; no job is issued.
- Reset mid-job returns to IDLE with all outputs at 0 and no abort pulse; the core shares the same reset.

## Timing
- Request to req_ready_o: 1 cycle from IDLE (the ARB cycle). Back-to-back jobs incur IDLE→ARB, so the minimum is 2 cycles after ack.
- req_ready_o to core_start_o: 1 cycle.
- core_done_i to rsp_valid_o: 1 cycle. irq_o is coincident with the first rsp_valid_o cycle.
- Timeout: core_abort_o pulses exactly TIMEOUT_CYCLES cycles after core_start_o. rsp_valid_o follows 1 cycle later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- LDPC_SCHED_STATS_EN defined:
  - jobs_done_o increments on every RESP ack, wrapping at 2^16.
  - timeouts_o increments on each ABORT entry, saturating at 255.
  - Both counters clear on reset.
- LDPC_SCHED_STATS_EN undefined: both ports remain present, tied to 0, and no counter flops are built.

## Structure
- Package ldpc_sched_pkg contains:
  - state enum: IDLE, ARB, START, RUN, ABORT, RESP;
  - status codes: ST_OK, ST_NOCONV, ST_TIMEOUT;
  - mode constants: MODE_ENC, MODE_DEC;
  - iteration field width: 5.
- One sub-module, ldpc_rr_arb: a 2-requester round-robin arbiter with a registered last-grant pointer, advanced only on an accepted grant.

## Test plan
- Single encode: requester 0 asserts valid, mode 0, iter 0; done after 10 cycles → req_ready_o=01 pulse, core_start_o next cycle, core_max_iter_o=1, rsp_status_o=00 on rsp_valid_o=01, one irq_o pulse, jobs_done_o=1 after ack.
- Decode not converged: requester 1, mode 1, iter 31 with ITER_MAX=16; done with converged=0 → core_max_iter_o=16, rsp_valid_o=10, rsp_status_o=01.
- Fairness: both requesters held valid for 4 jobs → grants alternate 0,1,0,1.
- Timeout: TIMEOUT_CYCLES=8, core never signals done → core_abort_o exactly 8 cycles after core_start_o, rsp_status_o=10, timeouts_o=1. Repeat with done on the timeout cycle → status 00 and no abort.
- Ack gating: in RESP, assert rsp_ack_i for the non-owner only → rsp_valid_o held; then owner ack → IDLE next cycle, busy_o=0.
- Reset mid-RUN: deassert wb_rst_n → all outputs 0 immediately, core_abort_o never pulses, and the next job is granted to requester 0 when both request.

Source files
------------

// File: rtl/ldpc_sched_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_sched_pkg
// Shared types and constants for the LDPC job scheduler:
//   sched_state_t : scheduler FSM states (IDLE, ARB, START, RUN, ABORT, RESP)
//   status_t      : per-job response codes returned to the requester
//   MODE_ENC/DEC  : job mode encoding on req_mode_i / core_mode_o
//   ITER_W        : width of the decoder iteration-budget field
// ---------------------------------------------------------------------------
package ldpc_sched_pkg;

    localparam int ITER_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        ABORT = 3'd4,
        RESP  = 3'd5
    } sched_state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_NOCONV  = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/ldpc_rr_arb.sv
// ---------------------------------------------------------------------------
// ldpc_rr_arb
// Two-requester round-robin arbiter. The grant is combinational from the
// request vector; the last-grant pointer is registered and only moves when
// the scheduler actually accepts a grant.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (pointer favours requester 0)
//   req    : request vector, bit i = requester i
//   accept : scheduler takes the current grant this cycle
//   grant  : one-hot grant, 2'b00 when nobody requests
// ---------------------------------------------------------------------------
module ldpc_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 means requester 1 won the most recent accepted grant.
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Resetting to 1 makes requester 0 win the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/ldpc_job_sched.sv
// ---------------------------------------------------------------------------
// ldpc_job_sched
// Job scheduler for the shared LDPC codec core. Two requesters (0: Wishbone
// front-end, 1: logic-analyzer path) are arbitrated round-robin; the winning
// job is started on the core, guarded by a RUN-state watchdog, and its status
// is returned to the owning requester together with a completion interrupt.
//
// Optional feature macro: LDPC_SCHED_STATS_EN
//   defined   -> jobs_done_o / timeouts_o are live statistics counters
//   undefined -> both ports tied to 0, no counter flops
//
// Ports:
//   wb_clk_i, wb_rst_n          clock, asynchronous active-low reset
//   req_valid_i/mode_i/iter_i   per-requester job request
//   req_ready_o                 one-cycle accept pulse to granted requester
//   core_start_o/abort_o        one-cycle controls to the codec core
//   core_mode_o/max_iter_o      job parameters held for the whole job
//   core_done_i/converged_i     codec completion and syndrome status
//   rsp_valid_o/status_o        response to owner, held until rsp_ack_i
//   busy_o, irq_o               activity flag, completion pulse
//   jobs_done_o, timeouts_o     statistics counters
// All outputs are registered.
// ---------------------------------------------------------------------------
module ldpc_job_sched
    import ldpc_sched_pkg::*;
#(
    parameter int ITER_MAX       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic [1:0]        req_valid_i,
    input  logic [1:0]        req_mode_i,
    input  logic [9:0]        req_iter_i,
    output logic [1:0]        req_ready_o,
    output logic              core_start_o,
    output logic              core_mode_o,
    output logic [ITER_W-1:0] core_max_iter_o,
    input  logic              core_done_i,
    input  logic              core_converged_i,
    output logic              core_abort_o,
    output logic [1:0]        rsp_valid_o,
    output logic [1:0]        rsp_status_o,
    input  logic [1:0]        rsp_ack_i,
    output logic              busy_o,
    output logic              irq_o,
    output logic [15:0]       jobs_done_o,
    output logic [7:0]        timeouts_o
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    sched_state_t      state;
    sched_state_t      next_state;

    logic [1:0]        grant;
    logic              arb_accept;
    logic              owner;
    logic              mode_sel;
    logic [ITER_W-1:0] iter_sel;
    logic [WD_W-1:0]   wd_cnt;
    logic              timeout_hit;

    logic [1:0]        req_ready_d;
    logic              core_start_d;
    logic              core_abort_d;
    logic              core_mode_d;
    logic [ITER_W-1:0] core_max_iter_d;
    logic [1:0]        rsp_valid_d;
    logic [1:0]        rsp_status_d;
    logic              busy_d;
    logic              irq_d;
    logic              owner_d;

    // Clamp the requested iteration budget into 1..ITER_MAX.
    function automatic logic [ITER_W-1:0] clamp_iter(input logic [ITER_W-1:0] v);
        if (v == '0) begin
            return ITER_W'(1);
        end else if (v > ITER_W'(ITER_MAX)) begin
            return ITER_W'(ITER_MAX);
        end else begin
            return v;
        end
    endfunction

    // Arbitration happens on the IDLE->ARB edge so that req_ready_o can be a
    // registered pulse that is visible during the ARB cycle itself.
    assign arb_accept = (state == IDLE) && (req_valid_i != 2'b00);

    ldpc_rr_arb u_arb (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .req    (req_valid_i),
        .accept (arb_accept),
        .grant  (grant)
    );

    assign mode_sel = grant[1] ? req_mode_i[1]   : req_mode_i[0];
    assign iter_sel = grant[1] ? req_iter_i[9:5] : req_iter_i[4:0];

    // Watchdog is cleared in START and holds (RUN cycles elapsed - 1) during
    // RUN. Leaving RUN when it reads TIMEOUT_CYCLES-2 (its next value would
    // reach TIMEOUT_CYCLES-1) puts the ABORT cycle exactly TIMEOUT_CYCLES
    // cycles after the START cycle.
    assign timeout_hit = (state == RUN) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wd_cnt <= '0;
        end else if (state == START) begin
            wd_cnt <= '0;
        end else if (state == RUN) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (req_valid_i != 2'b00) next_state = ARB;
            ARB:   next_state = START;
            START: next_state = RUN;
            // done takes priority over a coincident watchdog expiry
            RUN: begin
                if (core_done_i) begin
                    next_state = RESP;
                end else if (timeout_hit) begin
                    next_state = ABORT;
                end
            end
            ABORT: next_state = RESP;
            RESP:  if (rsp_ack_i[owner]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the
    // upcoming state so every output lines up with the state it belongs to.
    always_comb begin
        req_ready_d     = 2'b00;
        owner_d         = owner;
        core_mode_d     = core_mode_o;
        core_max_iter_d = core_max_iter_o;
        rsp_valid_d     = 2'b00;
        rsp_status_d    = ST_OK;
        irq_d           = 1'b0;
        core_start_d    = (next_state == START);
        core_abort_d    = (next_state == ABORT);
        busy_d          = (next_state != IDLE);

        if (arb_accept) begin
            req_ready_d     = grant;
            owner_d         = grant[1];
            core_mode_d     = mode_sel;
            core_max_iter_d = clamp_iter(iter_sel);
        end

        if (next_state == RESP) begin
            rsp_valid_d = owner ? 2'b10 : 2'b01;
            irq_d       = (state != RESP);
            case (state)
                RUN:     rsp_status_d = (core_mode_o == MODE_DEC && !core_converged_i)
                                        ? ST_NOCONV : ST_OK;
                ABORT:   rsp_status_d = ST_TIMEOUT;
                default: rsp_status_d = rsp_status_o;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            req_ready_o     <= 2'b00;
            owner           <= 1'b0;
            core_start_o    <= 1'b0;
            core_abort_o    <= 1'b0;
            core_mode_o     <= MODE_ENC;
            core_max_iter_o <= '0;
            rsp_valid_o     <= 2'b00;
            rsp_status_o    <= ST_OK;
            busy_o          <= 1'b0;
            irq_o           <= 1'b0;
        end else begin
            req_ready_o     <= req_ready_d;
            owner           <= owner_d;
            core_start_o    <= core_start_d;
            core_abort_o    <= core_abort_d;
            core_mode_o     <= core_mode_d;
            core_max_iter_o <= core_max_iter_d;
            rsp_valid_o     <= rsp_valid_d;
            rsp_status_o    <= rsp_status_d;
            busy_o          <= busy_d;
            irq_o           <= irq_d;
        end
    end

`ifdef LDPC_SCHED_STATS_EN
    logic [15:0] jobs_cnt;
    logic [7:0]  timeouts_cnt;

    // jobs_cnt wraps naturally; timeouts_cnt sticks at its maximum.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            jobs_cnt     <= '0;
            timeouts_cnt <= '0;
        end else begin
            if (state == RESP && next_state == IDLE) begin
                jobs_cnt <= jobs_cnt + 16'd1;
            end
            if (next_state == ABORT && state != ABORT && timeouts_cnt != 8'hFF) begin
                timeouts_cnt <= timeouts_cnt + 8'd1;
            end
        end
    end

    assign jobs_done_o = jobs_cnt;
    assign timeouts_o  = timeouts_cnt;
`else
    assign jobs_done_o = 16'd0;
    assign timeouts_o  = 8'd0;
`endif

endmodule

// File: tb/tb_ldpc_job_sched.sv
// ---------------------------------------------------------------------------
// tb_ldpc_job_sched
// Directed self-checking bench for ldpc_job_sched (ITER_MAX=16,
// TIMEOUT_CYCLES=8). Inputs change and outputs are sampled on the falling
// edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_ldpc_job_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_mode;
    logic [9:0]  req_iter;
    logic [1:0]  req_ready;
    logic        core_start;
    logic        core_mode;
    logic [4:0]  core_max_iter;
    logic        core_done;
    logic        core_conv;
    logic        core_abort;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_status;
    logic [1:0]  rsp_ack;
    logic        busy;
    logic        irq;
    logic [15:0] jobs_done;
    logic [7:0]  timeouts;
    logic [39:0] all_out;

    int n_cmp = 0;
    int n_err = 0;

`ifdef LDPC_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    ldpc_job_sched #(.ITER_MAX(16), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i        (clk),
        .wb_rst_n        (rst_n),
        .req_valid_i     (req_valid),
        .req_mode_i      (req_mode),
        .req_iter_i      (req_iter),
        .req_ready_o     (req_ready),
        .core_start_o    (core_start),
        .core_mode_o     (core_mode),
        .core_max_iter_o (core_max_iter),
        .core_done_i     (core_done),
        .core_converged_i(core_conv),
        .core_abort_o    (core_abort),
        .rsp_valid_o     (rsp_valid),
        .rsp_status_o    (rsp_status),
        .rsp_ack_i       (rsp_ack),
        .busy_o          (busy),
        .irq_o           (irq),
        .jobs_done_o     (jobs_done),
        .timeouts_o      (timeouts)
    );

    assign all_out = {req_ready, core_start, core_mode, core_max_iter, core_abort,
                      rsp_valid, rsp_status, busy, irq, jobs_done, timeouts};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 2'b00; req_mode = 2'b00; req_iter = 10'd0;
        core_done = 1'b0; core_conv = 1'b0; rsp_ack = 2'b00;
        tick; tick;
        n_cmp++; if (all_out !== 40'd0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        rst_n = 1'b1;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_encode;
        req_valid = 2'b01; req_mode = 2'b00; req_iter = 10'd0;
        tick; // ARB
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL enc_ready got=%b exp=01", req_ready); end
        n_cmp++; if (core_max_iter !== 5'd1) begin n_err++; $display("FAIL enc_iter_clamp0 got=%0d exp=1", core_max_iter); end
        n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL enc_start_early got=%b exp=0", core_start); end
        req_valid = 2'b00;
        tick; // START
        n_cmp++; if (core_start !== 1'b1) begin n_err++; $display("FAIL enc_start got=%b exp=1", core_start); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL enc_ready_pulse got=%b exp=00", req_ready); end
        tick; // RUN
        n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL enc_start_pulse got=%b exp=0", core_start); end
        tick; tick;
        core_done = 1'b1;
        tick; // RESP
        core_done = 1'b0;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL enc_rsp_valid got=%b exp=01", rsp_valid); end
        n_cmp++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL enc_status got=%b exp=00", rsp_status); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL enc_irq got=%b exp=1", irq); end
        tick;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL enc_irq_pulse got=%b exp=0", irq); end
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL enc_rsp_hold got=%b exp=01", rsp_valid); end
        rsp_ack = 2'b01;
        tick; // IDLE
        rsp_ack = 2'b00;
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL enc_rsp_clear got=%b exp=00", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL enc_busy_idle got=%b exp=0", busy); end
        n_cmp++; if (jobs_done !== (STATS ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL enc_jobs_done got=%0d exp=%0d", jobs_done, STATS ? 1 : 0); end
    endtask

    task automatic test_decode_noconv;
        req_valid = 2'b10; req_mode = 2'b10; req_iter = {5'd31, 5'd0};
        tick; // ARB
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL dec_ready got=%b exp=10", req_ready); end
        n_cmp++; if (core_max_iter !== 5'd16) begin n_err++; $display("FAIL dec_iter_clamp got=%0d exp=16", core_max_iter); end
        n_cmp++; if (core_mode !== 1'b1) begin n_err++; $display("FAIL dec_mode got=%b exp=1", core_mode); end
        req_valid = 2'b00;
        tick; // START
        tick; // RUN
        core_done = 1'b1; core_conv = 1'b0;
        tick; // RESP
        core_done = 1'b0;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL dec_rsp_valid got=%b exp=10", rsp_valid); end
        n_cmp++; if (rsp_status !== 2'b01) begin n_err++; $display("FAIL dec_status got=%b exp=01", rsp_status); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL dec_irq got=%b exp=1", irq); end
        rsp_ack = 2'b10;
        tick;
        rsp_ack = 2'b00;
        n_cmp++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL dec_status_clear got=%b exp=00", rsp_status); end
        // a stray done while idle must not start anything
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
        tick;
        n_cmp++; if ({busy, core_start, rsp_valid} !== 4'b0000) begin n_err++; $display("FAIL stray_done got=%b exp=0000", {busy, core_start, rsp_valid}); end
    endtask

    task automatic test_fairness;
        logic [1:0] exp;
        int w;
        req_valid = 2'b11; req_mode = 2'b00; req_iter = 10'd0; core_conv = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp = j[0] ? 2'b10 : 2'b01;
            w = 0;
            while (req_ready === 2'b00 && w < 6) begin tick; w++; end
            n_cmp++; if (req_ready !== exp) begin n_err++; $display("FAIL fair_grant%0d got=%b exp=%b", j, req_ready, exp); end
            tick; // START
            tick; // RUN
            core_done = 1'b1;
            tick; // RESP
            core_done = 1'b0;
            n_cmp++; if (rsp_valid !== exp) begin n_err++; $display("FAIL fair_rsp%0d got=%b exp=%b", j, rsp_valid, exp); end
            rsp_ack = exp;
            tick; // IDLE
            rsp_ack = 2'b00;
        end
        req_valid = 2'b00;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_idle got=%b exp=0", busy); end
    endtask

    task automatic test_timeout;
        int cyc;
        int aborts;
        req_valid = 2'b01; req_mode = 2'b00; req_iter = 10'd3;
        tick; // ARB
        req_valid = 2'b00;
        tick; // START
        n_cmp++; if (core_start !== 1'b1) begin n_err++; $display("FAIL to_start got=%b exp=1", core_start); end
        cyc = 0;
        while (core_abort !== 1'b1 && cyc < 20) begin tick; cyc++; end
        n_cmp++; if (cyc != 8) begin n_err++; $display("FAIL to_abort_latency got=%0d exp=8", cyc); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL to_rsp_early got=%b exp=00", rsp_valid); end
        tick; // RESP
        n_cmp++; if (core_abort !== 1'b0) begin n_err++; $display("FAIL to_abort_pulse got=%b exp=0", core_abort); end
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL to_rsp_valid got=%b exp=01", rsp_valid); end
        n_cmp++; if (rsp_status !== 2'b10) begin n_err++; $display("FAIL to_status got=%b exp=10", rsp_status); end
        n_cmp++; if (timeouts !== (STATS ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL to_count got=%0d exp=%0d", timeouts, STATS ? 1 : 0); end
        rsp_ack = 2'b01;
        tick;
        rsp_ack = 2'b00;
        // done lands on the last RUN cycle: done wins, no abort
        req_valid = 2'b01;
        tick; // ARB
        req_valid = 2'b00;
        tick; // START
        aborts = 0;
        repeat (7) begin tick; if (core_abort === 1'b1) aborts++; end
        core_done = 1'b1;
        tick; // RESP
        core_done = 1'b0;
        if (core_abort === 1'b1) aborts++;
        n_cmp++; if (aborts != 0) begin n_err++; $display("FAIL tie_abort got=%0d exp=0", aborts); end
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL tie_rsp_valid got=%b exp=01", rsp_valid); end
        n_cmp++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL tie_status got=%b exp=00", rsp_status); end
        n_cmp++; if (timeouts !== (STATS ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL tie_count got=%0d exp=%0d", timeouts, STATS ? 1 : 0); end
        rsp_ack = 2'b01;
        tick;
        rsp_ack = 2'b00;
    endtask

    task automatic test_ack_gating;
        req_valid = 2'b10; req_mode = 2'b10; req_iter = {5'd5, 5'd0};
        tick; // ARB
        n_cmp++; if (core_max_iter !== 5'd5) begin n_err++; $display("FAIL ack_iter_pass got=%0d exp=5", core_max_iter); end
        req_valid = 2'b00;
        tick; // START
        tick; // RUN
        core_done = 1'b1; core_conv = 1'b1;
        tick; // RESP
        core_done = 1'b0;
        n_cmp++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL ack_conv_status got=%b exp=00", rsp_status); end
        rsp_ack = 2'b01;
        tick;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL ack_nonowner_hold got=%b exp=10", rsp_valid); end
        tick;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ack_nonowner_busy got=%b exp=1", busy); end
        rsp_ack = 2'b10;
        tick;
        rsp_ack = 2'b00;
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL ack_owner_clear got=%b exp=00", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ack_owner_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run;
        int aborts;
        req_valid = 2'b01; req_mode = 2'b00; req_iter = {5'd0, 5'd20};
        tick; // ARB
        n_cmp++; if (core_max_iter !== 5'd16) begin n_err++; $display("FAIL rst_iter_clamp got=%0d exp=16", core_max_iter); end
        req_valid = 2'b00;
        tick; // START
        tick; // RUN
        tick; // RUN
        rst_n = 1'b0;
        #1;
        n_cmp++; if (all_out !== 40'd0) begin n_err++; $display("FAIL rst_async_outputs got=%h exp=0", all_out); end
        aborts = 0;
        repeat (3) begin tick; if (core_abort === 1'b1) aborts++; end
        rst_n = 1'b1;
        req_valid = 2'b11; req_mode = 2'b00; req_iter = 10'd0;
        tick; // ARB
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_rr_pointer got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        tick; // START
        if (core_abort === 1'b1) aborts++;
        tick; // RUN
        core_done = 1'b1;
        tick; // RESP
        core_done = 1'b0;
        n_cmp++; if (aborts != 0) begin n_err++; $display("FAIL rst_no_abort got=%0d exp=0", aborts); end
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rst_job_rsp got=%b exp=01", rsp_valid); end
        rsp_ack = 2'b01;
        tick;
        rsp_ack = 2'b00;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_job_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset;
        test_single_encode;
        test_decode_noconv;
        test_fairness;
        test_timeout;
        test_ack_gating;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
